// File: rtl/proc_ctrl.sv
`default_nettype none
// ============================================================================
// proc_ctrl : T0..T3 sequencer and decoder for a simple bus-based processor.
// Revision  : 1.0
// ============================================================================
module proc_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic       run,
    input  logic [8:0] din,
    output logic [7:0] rEn,
    output logic       aEn,
    output logic       gEn,
    output logic       addSub,
    output logic [3:0] busSel,
    output logic       done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] BUS_G   = 4'd8;
    localparam logic [3:0] BUS_DIN = 4'd9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     state_q, state_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_onehot;

    assign opcode    = ir_q[8:6];
    assign rx        = ir_q[5:3];
    assign ry        = ir_q[2:0];
    assign rx_onehot = 8'b0000_0001 << rx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= T0;
            ir_q    <= 9'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs depend only on state_q and ir_q; run and din only steer next state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        rEn     = 8'd0;
        aEn     = 1'b0;
        gEn     = 1'b0;
        addSub  = 1'b0;
        busSel  = BUS_DIN;
        done    = 1'b0;

        unique case (state_q)
            T0: begin
                if (run) begin
                    ir_d    = din;
                    state_d = T1;
                end
            end
            T1: begin
                unique case (opcode)
                    OP_MV: begin
                        busSel  = {1'b0, ry};
                        rEn     = rx_onehot;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        busSel  = BUS_DIN;
                        rEn     = rx_onehot;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        busSel  = {1'b0, rx};
                        aEn     = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        // Opcodes 1xx: retire immediately with no register writes.
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                busSel  = {1'b0, ry};
                gEn     = 1'b1;
                addSub  = ir_q[6];
                state_d = T3;
            end
            T3: begin
                busSel  = BUS_G;
                rEn     = rx_onehot;
                done    = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl.sv
`default_nettype none
// Testbench for proc_ctrl: randomized instruction stream, per-cycle expected
// control outputs queued by the driver and compared by an independent monitor.
module tb_proc_ctrl;

    logic       clk;
    logic       rstn;
    logic       run;
    logic [8:0] din;
    logic [7:0] rEn;
    logic       aEn;
    logic       gEn;
    logic       addSub;
    logic [3:0] busSel;
    logic       done;

    proc_ctrl dut (
        .clk    (clk),
        .rstn   (rstn),
        .run    (run),
        .din    (din),
        .rEn    (rEn),
        .aEn    (aEn),
        .gEn    (gEn),
        .addSub (addSub),
        .busSel (busSel),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] act;
    assign act = {rEn, aEn, gEn, addSub, busSel, done};

    function automatic logic [15:0] pk(input logic [7:0] r, input logic a,
                                       input logic g, input logic s,
                                       input logic [3:0] b, input logic d);
        return {r, a, g, s, b, d};
    endfunction

    localparam logic [15:0] IDLE = {8'd0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0};

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got rEn=%h aEn=%b gEn=%b addSub=%b busSel=%0d done=%b, expected rEn=%h aEn=%b gEn=%b addSub=%b busSel=%0d done=%b",
                     name, $time, got[15:8], got[7], got[6], got[5], got[4:1], got[0],
                     want[15:8], want[7], want[6], want[5], want[4:1], want[0]);
        end
    endtask

    // Monitor: one expected output vector per clock cycle.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", act, e);
            end
        end
    end

    // Reference model: the output sequence an instruction produces after its fetch.
    function automatic void expected_seq(input logic [8:0] instr, output logic [15:0] seq[$]);
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] oh;
        op = instr[8:6];
        x  = instr[5:3];
        y  = instr[2:0];
        oh = 8'd0;
        oh[x] = 1'b1;
        seq = {};
        if (op == 3'd0)
            seq.push_back(pk(oh, 0, 0, 0, {1'b0, y}, 1));
        else if (op == 3'd1)
            seq.push_back(pk(oh, 0, 0, 0, 4'd9, 1));
        else if (op == 3'd2 || op == 3'd3) begin
            seq.push_back(pk(8'd0, 1, 0, 0, {1'b0, x}, 0));
            seq.push_back(pk(8'd0, 0, 1, (op == 3'd3), {1'b0, y}, 0));
            seq.push_back(pk(oh, 0, 0, 0, 4'd8, 1));
        end else
            seq.push_back(pk(8'd0, 0, 0, 0, 4'd9, 1));
    endfunction

    task automatic step(input logic [15:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b0;
            din = 9'($urandom);
            step(IDLE);
        end
    endtask

    // Fetch in T0, then run the instruction with run/din scrambled in busy cycles.
    task automatic issue(input logic [8:0] instr, input logic [8:0] imm);
        logic [15:0] seq[$];
        expected_seq(instr, seq);
        run = 1'b1;
        din = instr;
        step(IDLE);
        foreach (seq[i]) begin
            run = 1'($urandom);
            din = (instr[8:6] == 3'd1) ? imm : 9'($urandom);
            step(seq[i]);
        end
    endtask

    // Add aborted by reset during T2.
    task automatic issue_reset(input logic [8:0] instr);
        logic [15:0] seq[$];
        expected_seq(instr, seq);
        run = 1'b1;
        din = instr;
        step(IDLE);
        run = 1'b0;
        step(seq[0]);
        exp_q.push_back(seq[1]);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("reset_mid_op", act, IDLE);
        @(posedge clk);
        #1;
        run = 1'b1;
        step(IDLE);
        rstn = 1'b1;
        run  = 1'b0;
        step(IDLE);
        step(IDLE);
    endtask

    initial begin
        logic [8:0] instr;
        rstn = 1'b0;
        run  = 1'b0;
        din  = 9'd0;
        #1;
        check("reset_async", act, IDLE);
        @(posedge clk);
        #1;
        run = 1'b1;
        step(IDLE);
        rstn = 1'b1;
        run  = 1'b0;
        step(IDLE);

        issue(9'b000_010_101, 9'd0);
        idle(1);
        issue(9'b001_111_000, 9'h05A);
        idle(2);
        issue(9'b011_001_010, 9'd0);
        issue(9'b000_011_011, 9'd0);
        issue(9'b010_011_011, 9'd0);
        issue(9'b010_100_110, 9'd0);
        issue(9'b000_110_001, 9'd0);
        issue(9'b110_000_000, 9'd0);
        idle(1);
        issue_reset(9'b010_101_001);
        issue(9'b000_000_111, 9'd0);

        for (int k = 0; k < 200; k++) begin
            instr = 9'($urandom);
            issue(instr, 9'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
